// File: rtl/clockgen_seq_if.sv
// Status/control bundle between the clock sequencer and its neighbours:
// DCM lock input plus the reset, ready, tick, fail and relock-count outputs.
interface clockgen_seq_if;
  logic       LOCKED_IN;
  logic       DCM_RST_OUT;
  logic       SYS_RST_OUT;
  logic       READY_OUT;
  logic       TICK_OUT;
  logic       FAIL_OUT;
  logic [7:0] RELOCK_CNT_OUT;

  modport master (
    output LOCKED_IN,
    input  DCM_RST_OUT, SYS_RST_OUT, READY_OUT, TICK_OUT, FAIL_OUT, RELOCK_CNT_OUT
  );

  modport slave (
    input  LOCKED_IN,
    output DCM_RST_OUT, SYS_RST_OUT, READY_OUT, TICK_OUT, FAIL_OUT, RELOCK_CNT_OUT
  );
endinterface

// File: rtl/clockgen_seq.sv
// DCM bring-up sequencer: pulses the DCM reset, waits for a stable lock with
// bounded retries, releases the USB-3W core and emits a divided tick strobe.
module clockgen_seq #(
  parameter int unsigned RST_CYCLES    = 3,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned MAX_RETRY     = 4,
  parameter int unsigned DIV           = 8
) (
  input logic           CLKIN_IN,
  input logic           RSTN_IN,
  clockgen_seq_if.slave cg
);

  localparam int unsigned RCW = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
  localparam int unsigned TOW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int unsigned STW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned DVW = (DIV           > 1) ? $clog2(DIV)           : 1;
  localparam int unsigned RTW = $clog2(MAX_RETRY + 1);
  localparam int unsigned RLW = 8;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           lock_m, lock_s;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic [STW-1:0] stb_cnt_q, stb_cnt_d;
  logic [DVW-1:0] div_cnt_q, div_cnt_d;
  logic [RTW-1:0] retry_q, retry_d;
  logic [RLW-1:0] relock_q, relock_d;
  logic           dcm_rst_q, dcm_rst_d;
  logic           sys_rst_q, sys_rst_d;
  logic           ready_q, ready_d;
  logic           tick_q, tick_d;
  logic           fail_q, fail_d;

  // Two-flop synchronizer for the asynchronous DCM lock
  always_ff @(posedge CLKIN_IN or negedge RSTN_IN) begin
    if (!RSTN_IN) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= cg.LOCKED_IN;
      lock_s <= lock_m;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLKIN_IN or negedge RSTN_IN) begin
    if (!RSTN_IN) begin
      state_q   <= S_RESET;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      stb_cnt_q <= '0;
      div_cnt_q <= '0;
      retry_q   <= '0;
      relock_q  <= '0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      tick_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      div_cnt_q <= div_cnt_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      dcm_rst_q <= dcm_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      tick_q    <= tick_d;
      fail_q    <= fail_d;
    end
  end

  // Next state; each counter runs only while its state is held, else clears
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    to_cnt_d  = '0;
    stb_cnt_d = '0;
    div_cnt_d = '0;
    retry_d   = retry_q;
    relock_d  = relock_q;

    case (state_q)
      S_RESET: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
        else                                   rst_cnt_d = rst_cnt_q + RCW'(1);
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (to_cnt_q == TOW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + RTW'(1);
          state_d = (retry_d == RTW'(MAX_RETRY)) ? S_FAIL : S_RESET;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      S_STABLE: begin
        // A lock drop here restarts without consuming a retry
        if (!lock_s) begin
          state_d = S_RESET;
        end else if (stb_cnt_q == STW'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          retry_d = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + STW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RESET;
          if (relock_q != {RLW{1'b1}}) relock_d = relock_q + RLW'(1);
        end else if (div_cnt_q != DVW'(DIV - 1)) begin
          div_cnt_d = div_cnt_q + DVW'(1);
        end
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_RESET;
    endcase

    // Outputs registered from the next state so they line up with state_q
    dcm_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    tick_d    = (state_d == S_RUN) && (div_cnt_d == DVW'(DIV - 1));
    fail_d    = (state_d == S_FAIL);
  end

  assign cg.DCM_RST_OUT    = dcm_rst_q;
  assign cg.SYS_RST_OUT    = sys_rst_q;
  assign cg.READY_OUT      = ready_q;
  assign cg.TICK_OUT       = tick_q;
  assign cg.FAIL_OUT       = fail_q;
  assign cg.RELOCK_CNT_OUT = relock_q;

endmodule

// File: tb/tb_clockgen_seq.sv
// Directed bench for clockgen_seq: phase table for bring-up, tick, relock and
// glitch, then hand sequences for async reset, timeout/fail, recovery, saturation.
module tb_clockgen_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  clockgen_seq_if cg();

  clockgen_seq #(
    .RST_CYCLES(3), .LOCK_TIMEOUT(1024), .STABLE_CYCLES(16), .MAX_RETRY(4), .DIV(8)
  ) dut (
    .CLKIN_IN(clk),
    .RSTN_IN (rst_n),
    .cg      (cg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       locked;
    int         ncyc;
    logic       dcm;
    logic       sys;
    logic       rdy;
    logic       tick;
    logic       fail;
    logic [7:0] relock;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rstn, input logic locked, input int ncyc,
                     input logic dcm, input logic sys, input logic rdy,
                     input logic tick, input logic fail, input logic [7:0] relock);
    vec_t v;
    v.rstn = rstn; v.locked = locked; v.ncyc = ncyc;
    v.dcm = dcm; v.sys = sys; v.rdy = rdy; v.tick = tick; v.fail = fail; v.relock = relock;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, required %0d", name, idx, act, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input int idx, input vec_t v);
    chk({tag, "_dcm_rst"}, idx, 32'(cg.DCM_RST_OUT), 32'(v.dcm));
    chk({tag, "_sys_rst"}, idx, 32'(cg.SYS_RST_OUT), 32'(v.sys));
    chk({tag, "_ready"},   idx, 32'(cg.READY_OUT),   32'(v.rdy));
    chk({tag, "_tick"},    idx, 32'(cg.TICK_OUT),    32'(v.tick));
    chk({tag, "_fail"},    idx, 32'(cg.FAIL_OUT),    32'(v.fail));
    chk({tag, "_relock"},  idx, 32'(cg.RELOCK_CNT_OUT), 32'(v.relock));
  endtask

  initial begin
    int   cyc;
    int   falls;
    int   ticks;
    int   lowrun;
    int   n;
    logic prev;
    vec_t rv;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    cg.LOCKED_IN = 1'b0;

    //   rstn lock ncyc  dcm sys rdy tick fail relock
    add(1'b0, 1'b0,  2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // held in reset
    add(1'b1, 1'b0,  2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // RESET, pulse cycles 1-2
    add(1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // 3-cycle pulse ended
    add(1'b1, 1'b0,  9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // WAIT_LOCK
    add(1'b1, 1'b1, 18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // sync + STABLE
    add(1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); // RUN entry
    add(1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0); // first tick, 8th RUN cycle
    add(1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0); // second tick
    add(1'b1, 1'b0,  2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); // lock lost, still syncing
    add(1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1); // RESET 3 cycles after drop
    add(1'b1, 1'b0,  3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1); // WAIT_LOCK
    add(1'b1, 1'b1, 19, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1); // back in RUN
    add(1'b1, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2); // second loss
    add(1'b1, 1'b0,  3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b1,  7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2); // STABLE, partway
    add(1'b1, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2); // glitch -> RESET, no relock
    add(1'b1, 1'b1,  2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2); // new pulse exactly 3 cycles
    add(1'b1, 1'b1, 17, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2); // RUN after clean lock
    add(1'b1, 1'b1,  7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // reset from RUN

    @(negedge clk);
    foreach (vq[i]) begin
      rst_n = vq[i].rstn;
      cg.LOCKED_IN = vq[i].locked;
      repeat (vq[i].ncyc) step();
      chk_all("vec", i, vq[i]);
    end

    // Asynchronous reset in WAIT_LOCK takes effect before the next edge
    rst_n = 1'b1;
    cg.LOCKED_IN = 1'b0;
    repeat (5) step();
    chk("wait_dcm_rst", 0, 32'(cg.DCM_RST_OUT), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    rv = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    chk_all("async_rst", 0, rv);

    // Lock never arrives: four attempts of 3 + 1024 cycles, then FAIL
    @(negedge clk);
    rst_n = 1'b1;
    prev = 1'b1; falls = 0; ticks = 0; lowrun = 0; cyc = 0;
    while (cg.FAIL_OUT !== 1'b1 && cyc < 6000) begin
      step();
      cyc++;
      if (cg.TICK_OUT === 1'b1) ticks++;
      if (prev && !cg.DCM_RST_OUT) begin
        falls++;
        lowrun = 0;
      end
      if (!cg.DCM_RST_OUT) lowrun++;
      if (!prev && cg.DCM_RST_OUT) chk("wait_len", falls, 32'(lowrun), 32'd1024);
      prev = cg.DCM_RST_OUT;
    end
    chk("fail_cycles", 0, 32'(cyc), 32'd4108);
    chk("fail_pulses", 0, 32'(falls), 32'd4);
    repeat (20) begin
      step();
      if (cg.TICK_OUT === 1'b1) ticks++;
    end
    chk("fail_ticks", 0, 32'(ticks), 32'd0);
    rv = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    chk_all("fail_hold", 0, rv);

    // Only RSTN_IN leaves FAIL; bring-up with lock already present
    rst_n = 1'b0;
    #1;
    rv = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    chk_all("fail_rst", 0, rv);
    cg.LOCKED_IN = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (cg.READY_OUT !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("recover_latency", 0, 32'(n), 32'd20);
    chk("recover_fail", 0, 32'(cg.FAIL_OUT), 32'd0);

    // Repeated one-cycle lock losses in RUN; count saturates at 255
    for (int i = 0; i < 300; i++) begin
      cg.LOCKED_IN = 1'b0;
      step();
      cg.LOCKED_IN = 1'b1;
      step();
      if (i < 3) chk("relock_sys_pre", i, 32'(cg.SYS_RST_OUT), 32'd0);
      step();
      if (i < 3) begin
        chk("relock_sys_post", i, 32'(cg.SYS_RST_OUT), 32'd1);
        chk("relock_tick", i, 32'(cg.TICK_OUT), 32'd0);
      end
      n = 0;
      while (cg.READY_OUT !== 1'b1 && n < 100) begin
        step();
        n++;
      end
      chk("relock_ready", i, 32'(cg.READY_OUT), 32'd1);
      chk("relock_cnt", i, 32'(cg.RELOCK_CNT_OUT), (i < 255) ? 32'(i + 1) : 32'd255);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
